// File: rtl/data_memory_sized_pkg.sv
// data_memory_sized_pkg: access-size encodings, FSM states and the alignment rule
package data_memory_sized_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    typedef enum logic {ST_INIT, ST_IDLE} state_e;
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00) || size == SZ_RSVD;
    endfunction
endpackage

// File: rtl/data_memory_sized_mem_lane_align.sv
// mem_lane_align: places store data into byte lanes and extracts/extends load data
module mem_lane_align
    import data_memory_sized_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wword,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata
);
    logic [4:0]  w_shift;
    logic [3:0]  w_mask;
    logic [31:0] w_sh;
    always_comb begin
        w_shift = {i_offset, 3'b000};
        w_mask  = (i_size == SZ_BYTE) ? 4'b0001 : (i_size == SZ_HALF) ? 4'b0011 : 4'b1111;
        o_wword = i_wdata << w_shift;
        o_wstrb = w_mask << i_offset;
        w_sh    = i_rword >> w_shift;
        o_rdata = (i_size == SZ_BYTE) ? {{24{i_sign_ext & w_sh[7]}}, w_sh[7:0]} :
                  (i_size == SZ_HALF) ? {{16{i_sign_ext & w_sh[15]}}, w_sh[15:0]} : w_sh;
    end
endmodule

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte/half/word data memory with zero-fill sweep after reset
module data_memory_sized
    import data_memory_sized_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_WIDTH  = $clog2(DEPTH_WORDS) + 2,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [1:0]            Size,
    input  logic                  SignExtend,
    output logic [31:0]           ReadData,
    output logic                  ReadValid,
    output logic                  Ready,
    output logic                  Misaligned
);
    localparam int IW = $clog2(DEPTH_WORDS);
    logic [31:0]   r_mem [DEPTH_WORDS];
    state_e        r_state, w_next;
    logic [IW-1:0] r_count;
    logic [31:0]   r_read_data;
    logic          r_read_valid, r_misaligned;
    logic [IW-1:0] w_idx;
    logic          w_mis, w_load, w_any, w_store, w_init_we;
    logic [31:0]   w_wword, w_rdata;
    logic [3:0]    w_wstrb;
    assign w_idx     = Address[ADDR_WIDTH-1:2];
    assign w_mis     = is_misaligned(Size, Address[1:0]);
    assign w_load    = Ready && MemoryRead;
    assign w_any     = Ready && (MemoryRead || MemoryWrite);
    assign w_store   = Ready && MemoryWrite && !w_mis;
    // sweep writes are held off while Reset is high so the array is only cleared by the sweep proper
    assign w_init_we = r_state == ST_INIT && INIT_CLEAR && !Reset;
    assign Ready      = r_state == ST_IDLE;
    assign ReadData   = r_read_data;
    assign ReadValid  = r_read_valid;
    assign Misaligned = r_misaligned;
    mem_lane_align u_align (
        .i_size     (Size),
        .i_offset   (Address[1:0]),
        .i_sign_ext (SignExtend),
        .i_wdata    (WriteData),
        .i_rword    (r_mem[w_idx]),
        .o_wword    (w_wword),
        .o_wstrb    (w_wstrb),
        .o_rdata    (w_rdata)
    );
    always_comb begin
        w_next = (r_state == ST_INIT && (!INIT_CLEAR || r_count == IW'(DEPTH_WORDS - 1))) ? ST_IDLE : r_state;
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= (r_state == ST_INIT) ? r_count + 1'b1 : '0;
        end
    end
    // the load path samples the array before this edge's store lands, giving read-first behaviour
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_read_valid <= w_load;
            r_misaligned <= w_any && w_mis;
            if (w_any && w_mis)
                r_read_data <= '0;
            else if (w_load)
                r_read_data <= w_rdata;
        end
    end
    always_ff @(posedge Clock) begin
        if (w_init_we)
            r_mem[r_count] <= '0;
        else if (w_store)
            for (int b = 0; b < 4; b++)
                if (w_wstrb[b])
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: randomized and directed checks against a byte-array reference model
module tb_data_memory_sized;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemoryRead = 1'b0, MemoryWrite = 1'b0, SignExtend = 1'b0;
    logic [1:0]  Size = 2'b10;
    logic [31:0] ReadData, ReadData2;
    logic        ReadValid, Ready, Misaligned, ReadValid2, Ready2, Misaligned2;
    logic [7:0]  mem_m [256];
    logic [31:0] last_rd = '0;
    int          n_cmp = 0, n_err = 0;

    data_memory_sized dut (
        .Clock(Clock), .Reset(Reset), .Address(Address), .WriteData(WriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .Size(Size), .SignExtend(SignExtend),
        .ReadData(ReadData), .ReadValid(ReadValid), .Ready(Ready), .Misaligned(Misaligned)
    );
    data_memory_sized #(.INIT_CLEAR(1'b0)) dut_nc (
        .Clock(Clock), .Reset(Reset), .Address(Address), .WriteData(WriteData),
        .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .Size(Size), .SignExtend(SignExtend),
        .ReadData(ReadData2), .ReadValid(ReadValid2), .Ready(Ready2), .Misaligned(Misaligned2)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic bit mis_m(input int a, input int sz);
        return (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || sz == 3;
    endfunction

    function automatic logic [31:0] load_m(input int a, input int sz, input bit sx);
        int v;
        if (mis_m(a, sz)) return 0;
        if (sz == 0) begin
            v = mem_m[a];
            return (sx && v >= 128) ? 32'(v) | 32'hFFFFFF00 : 32'(v);
        end
        if (sz == 1) begin
            v = mem_m[a] + 256 * mem_m[a+1];
            return (sx && v >= 32768) ? 32'(v) | 32'hFFFF0000 : 32'(v);
        end
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    task automatic clear_m();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    endtask

    // issues one request for one cycle, then checks the registered response against the model
    task automatic do_req(input string tag, input bit rd, input bit wr, input int a, input int sz,
                          input bit sx, input logic [31:0] wd);
        bit mis;
        logic [31:0] exp_load;
        int nb;
        Address = 8'(a); Size = 2'(sz); SignExtend = sx; WriteData = wd;
        MemoryRead = rd; MemoryWrite = wr;
        mis = mis_m(a, sz);
        exp_load = load_m(a, sz, sx);
        if ((rd || wr) && mis) last_rd = 0;
        else if (rd) last_rd = exp_load;
        if (wr && !mis) begin
            nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            for (int i = 0; i < nb; i++) mem_m[a+i] = 8'((wd >> (8*i)) & 32'hFF);
        end
        tick();
        check({tag, "_rv"}, 32'(ReadValid), 32'(rd));
        check({tag, "_mis"}, 32'(Misaligned), 32'((rd || wr) && mis));
        check({tag, "_rd"}, ReadData, last_rd);
    endtask

    task automatic idle();
        MemoryRead = 1'b0; MemoryWrite = 1'b0;
    endtask

    // releases reset and counts edges until Ready; returns the count
    task automatic release_and_wait(output int n, output int rv_seen);
        n = 0; rv_seen = 0;
        Reset = 1'b0;
        while (!Ready && n < 200) begin
            tick();
            n++;
            if (n == 1) check("nc_ready_1", 32'(Ready2), 32'd1);
            rv_seen += int'(ReadValid) + int'(Misaligned);
        end
    endtask

    initial begin
        int n, rv;
        int a, sz;
        bit rd, wr;
        #3;
        check("rst_rd", ReadData, 32'h0);
        check("rst_rv", 32'(ReadValid), 32'h0);
        check("rst_ready", 32'(Ready), 32'h0);
        check("rst_mis", 32'(Misaligned), 32'h0);
        tick();
        MemoryRead = 1'b1; Address = 8'h00; Size = 2'b10;
        release_and_wait(n, rv);
        idle();
        check("init_latency", 32'(n), 32'd64);
        check("init_no_resp", 32'(rv), 32'd0);
        clear_m();
        do_req("ld_0fc", 1, 0, 'hFC, 2, 0, 0);
        check("ld_0fc_val", ReadData, 32'h0);
        do_req("st_dead", 0, 1, 'h10, 2, 0, 32'hDEADBEEF);
        do_req("ldb_sx1", 1, 0, 'h13, 0, 1, 0);
        check("ldb_sx1_val", ReadData, 32'hFFFFFFDE);
        do_req("ldb_sx0", 1, 0, 'h13, 0, 0, 0);
        check("ldb_sx0_val", ReadData, 32'h000000DE);
        do_req("st_half", 0, 1, 'h12, 1, 0, 32'h00001234);
        do_req("ldw_010", 1, 0, 'h10, 2, 1, 0);
        check("ldw_010_val", ReadData, 32'h1234BEEF);
        do_req("mis_ldw", 1, 0, 'h11, 2, 0, 0);
        do_req("mis_sth", 0, 1, 'h13, 1, 0, 32'hFFFF);
        do_req("mis_rsvd", 1, 0, 'h10, 3, 0, 0);
        do_req("ldw_after", 1, 0, 'h10, 2, 0, 0);
        check("ldw_after_val", ReadData, 32'h1234BEEF);
        do_req("rw_same", 1, 1, 'h20, 2, 0, 32'hA5A5A5A5);
        check("rw_same_old", ReadData, 32'h0);
        do_req("rw_next", 1, 0, 'h20, 2, 0, 0);
        check("rw_next_val", ReadData, 32'hA5A5A5A5);
        idle();
        tick();
        check("hold_rd", ReadData, 32'hA5A5A5A5);
        check("hold_rv", 32'(ReadValid), 32'h0);
        for (int i = 0; i < 400; i++) begin
            sz = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = (sz == 1) ? (a & ~1) : (sz >= 2) ? (a & ~3) : a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            do_req("rnd", rd, wr, a, sz, 1'($urandom_range(0, 1)), $urandom);
        end
        idle();
        // a load in flight when reset arrives must never complete
        MemoryRead = 1'b1; Address = 8'h20; Size = 2'b10;
        #2 Reset = 1'b1;
        #1;
        check("abort_rv", 32'(ReadValid), 32'h0);
        check("abort_ready", 32'(Ready), 32'h0);
        check("abort_rd", ReadData, 32'h0);
        tick();
        check("abort_rv_edge", 32'(ReadValid), 32'h0);
        idle();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_sweep_ready", 32'(Ready), 32'h0);
        #2 Reset = 1'b1;
        tick();
        check("mid_sweep_rst_ready", 32'(Ready), 32'h0);
        release_and_wait(n, rv);
        check("resweep_latency", 32'(n), 32'd64);
        clear_m();
        do_req("resweep_ld20", 1, 0, 'h20, 2, 0, 0);
        do_req("resweep_ld10", 1, 0, 'h10, 2, 0, 0);
        check("resweep_zero", ReadData, 32'h0);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
